// File: rtl/ram_pkg.sv
// Shared defaults and state encoding for the single-clock synchronous RAM.
package ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

endpackage : ram_pkg

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then
// hands the memory over to the user port and raises init_done.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ram_state_t        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_init_done;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_ptr <= r_ptr + ADDR_W'(1);
      if (r_ptr == LAST_ADDR) begin
        r_state     <= READY;
        r_init_done <= 1'b1;
      end
    end
  end

  assign clr_we    = (r_state == CLEAR);
  assign clr_addr  = r_ptr;
  assign clr_data  = '0;
  assign init_done = r_init_done;

endmodule : ram_clear_seq

// File: rtl/single_clock_sync_ram.sv
// Simple-dual-port synchronous RAM with 1-cycle registered read and a
// post-reset clear. Define RAM_RDW_BYPASS_EN for write-first same-address reads.
module single_clock_sync_ram
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              we,
  output logic [DATA_W-1:0] q,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [DATA_W-1:0] w_clr_data;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  ram_clear_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .clr_data  (w_clr_data),
    .init_done (init_done)
  );

  // The sequencer owns the write port while clearing; nothing writes on a reset edge.
  assign w_mem_we   = rst_n & (w_clr_we | we);
  assign w_mem_addr = w_clr_we ? w_clr_addr : write_addr;
  assign w_mem_data = w_clr_we ? w_clr_data : data;

  // NOTE: the array has no reset branch; a per-word reset would prevent
  // block-RAM inference, so zeroing is done by the clear sequencer instead.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_mem_addr] <= w_mem_data;
    end
  end

`ifdef RAM_RDW_BYPASS_EN
  logic [DATA_W-1:0] r_q_mem;
  logic [DATA_W-1:0] r_byp_data;
  logic              r_byp_hit;

  always_ff @(posedge clk) begin
    if (!rst_n || w_clr_we) begin
      r_q_mem   <= '0;
      r_byp_hit <= 1'b0;
    end else begin
      r_q_mem   <= mem[read_addr];
      r_byp_hit <= we && (write_addr == read_addr);
    end
  end

  // Data register needs no reset: it is only selected while r_byp_hit is set.
  always_ff @(posedge clk) begin
    r_byp_data <= data;
  end

  assign q = r_byp_hit ? r_byp_data : r_q_mem;
`else
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n || w_clr_we) begin
      r_q <= '0;
    end else begin
      r_q <= mem[read_addr];
    end
  end

  assign q = r_q;
`endif

endmodule : single_clock_sync_ram

// File: tb/tb_single_clock_sync_ram.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// array-based reference memory with a clear countdown.
module tb_single_clock_sync_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

`ifdef RAM_RDW_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] write_addr;
  logic [ADDR_W-1:0] read_addr;
  logic              we;
  logic [DATA_W-1:0] q;
  logic              init_done;

  single_clock_sync_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .write_addr (write_addr),
    .read_addr  (read_addr),
    .we         (we),
    .q          (q),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                clear_left;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after a negedge, predict, check at the next negedge.
  task automatic step(input logic r, input logic w, input int wa, input int ra, input int d);
    logic [DATA_W-1:0] exp_q;
    logic              exp_done;
    rst_n      = r;
    we         = w;
    write_addr = ADDR_W'(wa);
    read_addr  = ADDR_W'(ra);
    data       = DATA_W'(d);
    if (!r) begin
      clear_left = DEPTH;
      exp_q      = '0;
      exp_done   = 1'b0;
    end else if (clear_left > 0) begin
      model_mem[DEPTH - clear_left] = '0;
      clear_left--;
      exp_q    = '0;
      exp_done = (clear_left == 0);
    end else begin
      if (BYPASS && w && (wa == ra)) exp_q = DATA_W'(d);
      else                           exp_q = model_mem[ra];
      if (w) model_mem[wa] = DATA_W'(d);
      exp_done = 1'b1;
    end
    @(negedge clk);
    check("q", 32'(q), 32'(exp_q));
    check("init_done", 32'(init_done), 32'(exp_done));
  endtask

  task automatic idle_read(input int ra);
    step(1'b1, 1'b0, 0, ra, 0);
  endtask

  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;
    clear_left = DEPTH;
    rst_n = 1'b0; we = 1'b0; data = '0; write_addr = '0; read_addr = '0;
    @(negedge clk);

    // Reset held, then full clear; a user write at clear cycle 5 must be ignored.
    repeat (3) step(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 5) step(1'b1, 1'b1, 10, 0, 8'hFF);
      else        step(1'b1, 1'b0, 0, i, 0);
    end
    for (int i = 0; i < DEPTH; i++) idle_read(i);
    idle_read(10);
    check("addr10_after_clear", 32'(model_mem[10]), 32'h0);

    // Basic write/read
    step(1'b1, 1'b1, 5, 0, 8'hA5);
    step(1'b1, 1'b1, 63, 0, 8'h3C);
    idle_read(5);
    idle_read(63);
    idle_read(0);

    // Read-during-write at the same address
    step(1'b1, 1'b1, 7, 0, 8'h11);
    step(1'b1, 1'b1, 7, 7, 8'h22);
    idle_read(7);
    idle_read(7);

    // we = 0 leaves memory unchanged
    step(1'b1, 1'b1, 20, 0, 8'h5A);
    repeat (10) step(1'b1, 1'b0, 20, 3, 8'h00);
    idle_read(20);
    idle_read(20);

    // Mid-operation reset with a write pending on the reset edge
    step(1'b1, 1'b1, 1, 0, 8'h77);
    idle_read(1);
    step(1'b0, 1'b1, 2, 1, 8'h99);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, 1, 0);
    idle_read(1);
    idle_read(2);

    // Randomized traffic with biased address collisions and rare resets
    for (int n = 0; n < 3000; n++) begin
      int  wa, ra, d;
      logic w, r;
      wa = $urandom_range(DEPTH - 1);
      ra = ($urandom_range(3) == 0) ? wa : $urandom_range(DEPTH - 1);
      d  = $urandom_range(255);
      w  = ($urandom_range(1) == 1);
      r  = ($urandom_range(400) != 0);
      step(r, w, wa, ra, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_single_clock_sync_ram

// File: doc/single_clock_sync_ram.md
Name: single_clock_sync_ram

Overview:
- Single-clock, simple-dual-port synchronous RAM: one write port and one read port, independent addresses, 64 x 8 by default.
- Registered read output with one-cycle latency. Coded so synthesis infers block RAM.
- Built-in post-reset clear sequencer zeroes every word before normal operation.
- Used as a generic scratch/buffer memory inside datapath blocks.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 6, address width in bits; DEPTH = 2**ADDR_W (64 words).

Ports:
- clk  input  1  rising-edge clock for all logic.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- data  input  DATA_W  write data.
- write_addr  input  ADDR_W  write address.
- read_addr  input  ADDR_W  read address.
- we  input  1  write enable, active high.
- q  output  DATA_W  registered read data.
- init_done  output  1  high once the clear sequence has finished; low during reset and while clearing.

Behaviour:
- Reset: when rst_n = 0 at a rising clk edge:
  - q <= 0, init_done <= 0.
  - Clear pointer <= 0, state <= CLEAR.
  - Memory contents are not touched during reset itself.
- State machine has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr.
  - The cycle that writes mem[DEPTH-1] moves the state to READY and sets init_done <= 1 on that same edge.
  - CLEAR therefore takes exactly DEPTH cycles (64) after rst_n rises.
  - During CLEAR: we is ignored (no user write), q is held at 0.
- READY, write path: at a rising edge with we = 1, mem[write_addr] <= data. With we = 0, memory is unchanged.
- READY, read path: at every rising edge, q <= mem[read_addr].
  - The read is unconditional; there is no read enable.
  - Latency is 1 cycle: q reflects read_addr sampled at the previous edge.
- Read-during-write, same address (default): read-first, i.e. q gets the old contents. The new data is visible on a read issued on the next edge or later.
- Read and write at different addresses in the same cycle are fully independent.
- Invariant in READY: one cycle after a read of address A with no intervening write to A, q == mem[A].
- Reset asserted mid-operation:
  - Abandons the current state; q = 0 and init_done = 0 on the next edge.
  - A fresh full clear runs after release; any write pending on the reset edge is dropped.
- Address wrap: ptr is ADDR_W bits wide. No address is out of range, so no bounds checking is needed.
- Memory is a single array reg [DATA_W-1:0] mem [0:DEPTH-1]. It must not have a per-word reset, so that block-RAM inference is preserved.

Optional Feature:
- Macro: RAM_RDW_BYPASS_EN.
- Defined:
  - On a same-address read and write with we = 1 in READY, q <= data (write-first / forwarding).
  - Implemented with a registered address-compare bypass mux after the array read.
- Undefined: read-first behaviour as above.
- No other behaviour changes; port list is identical in both builds.

Decomposition:
- Package ram_pkg holds:
  - DATA_W_DEF = 8 and ADDR_W_DEF = 6.
  - typedef enum logic {CLEAR, READY} ram_state_t.
- One sub-module is natural: ram_clear_seq, containing the state register, ptr counter and init_done.
  - It outputs clr_we, clr_addr and clr_data (= 0).
  - The top level muxes these against the user write port.
- The memory array and read register stay in the top level.

Test Plan:
- Reset/clear:
  - Hold rst_n = 0 for 3 cycles, then release. Expect q = 0 throughout and init_done = 0 for 64 cycles, then init_done = 1.
  - Then read all 64 addresses; each returns 0x00 one cycle later.
- Basic write/read:
  - Write 0xA5 to addr 5, then 0x3C to addr 63.
  - Read addr 5: q = 0xA5 on the next edge. Read addr 63: q = 0x3C.
- Write during CLEAR:
  - Assert we = 1, write_addr = 10, data = 0xFF at cycle 5 of the clear.
  - After init_done, a read of addr 10 returns 0x00.
- Read-during-write, same address:
  - Pre-load addr 7 = 0x11. In one cycle: we = 1, data = 0x22, write_addr = read_addr = 7.
  - Expect q = 0x11 next cycle, and 0x22 on the following read.
  - With RAM_RDW_BYPASS_EN defined, expect q = 0x22 immediately.
- we = 0 holds memory:
  - With addr 20 = 0x5A, drive we = 0, write_addr = 20, data = 0x00 for 10 cycles.
  - A read of addr 20 still returns 0x5A.
- Mid-operation reset:
  - After writing addr 1 = 0x77, pulse rst_n low for 1 cycle.
  - Expect q = 0 and init_done = 0, a full 64-cycle clear, then a read of addr 1 returns 0x00.
